fetch_ctrl: RTL and testbench
=============================

Name: fetch_ctrl

Overview:
- Instruction-fetch sequencer that owns the program counter and drives the combinational instruction ROM address every cycle.
- Buffers fetched words, each paired with its PC, in a small prefetch FIFO, and presents them to decode through a valid/ready handshake.
- Accepts branch redirects from execute.
- Detects misaligned or out-of-bounds fetches and halts in a fault state until a legal redirect arrives.

Parameters:
- RESET_PC, 64'd0, PC loaded on reset.
- MEM_SIZE, 1024, instruction ROM size in bytes; power of two, > 4.
- DEPTH, 4, prefetch FIFO entries; power of two, >= 2.

Ports:
- clk  in  1  system clock, posedge.
- reset  in  1  asynchronous, active-high reset.
- imem_addr  out  64  byte address to instruction ROM; equals fetch_pc combinationally.
- imem_instr  in  32  ROM read data; combinational from imem_addr.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  decode accepts head this cycle.
- out_instr  out  32  head instruction.
- out_pc  out  64  head instruction's PC.
- redirect  in  1  branch taken; load redirect_pc.
- redirect_pc  in  64  branch target byte address.
- fault  out  1  fetch halted on an illegal address.
- fault_pc  out  64  offending address, valid while fault=1.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high, on port reset.
- Reset values: fetch_pc=RESET_PC; FIFO empty; out_valid=0; out_instr=0; out_pc=0; fault=0; fault_pc=0; state=FETCH.
- States:
  - FETCH: normal sequential fetch.
  - FAULT: no pushes; imem_addr holds fetch_pc.
- Legal address: addr[1:0]==0 and addr+3 < MEM_SIZE. Compare using 64-bit unsigned arithmetic; the addition wraps to 64 bits.
- Pop: occurs when out_valid && out_ready. out_valid=!empty; out_instr and out_pc come from the head entry.
- Push in FETCH (no redirect): occurs when fetch_pc is legal and (!full || pop).
  - Writes {fetch_pc, imem_instr} to the tail.
  - fetch_pc += 4.
  - Full with a same-cycle pop is allowed; count is unchanged.
- Stall: if full and no pop, fetch_pc holds. imem_addr stays stable; no loss, no duplication.
- Illegal fetch_pc in FETCH (no redirect): no push; next state FAULT; fault_pc=fetch_pc.
  - FIFO contents remain poppable, so older instructions drain normally.
- Redirect (highest priority, any state):
  - FIFO cleared at the edge. A same-cycle pop still counts as accepted by decode.
  - The same-cycle push is suppressed.
  - If redirect_pc is legal: fetch_pc=redirect_pc, state=FETCH, fault=0.
  - If redirect_pc is illegal: fetch_pc=redirect_pc, state=FAULT, fault=1, fault_pc=redirect_pc.
- Latency:
  - Redirect sampled at edge N: the target is fetched during cycle N+1, pushed at edge N+1, and out_valid=1 after edge N+1.
  - Reset release behaves the same: the first instruction is valid one edge after the first active edge.
- Occupancy: count ranges 0..DEPTH. Read/write pointers are log2(DEPTH) bits and wrap naturally.
- Reset mid-operation: everything returns to reset values immediately (asynchronous); in-flight entries are discarded.
- FAULT exit: only via a legal redirect or reset.

Decomposition:
- Shared package fetch_pkg holds:
  - fetch_state_e {FETCH, FAULT}.
  - fetch_entry_t struct {logic [63:0] pc; logic [31:0] instr}.
  - INSTR_BYTES=4 constant.
- Sub-module fetch_fifo:
  - Parameterized on DEPTH; stores fetch_entry_t.
  - Ports: push, pop, flush, full, empty, head.
  - flush has priority over push.
- fetch_ctrl contains: PC register, legality check, state machine, fault registers.

Test Plan:
- Reset then out_ready=1 steady, ROM words I0..I3 at 0,4,8,12 -> out_valid rises one edge after reset release; out_pc sequence 0,4,8,12 on consecutive cycles; each out_instr matches its word.
- out_ready=0 for 10 cycles -> exactly DEPTH=4 entries (pc 0..12); imem_addr holds 16. Raise out_ready -> pcs 0,4,8,12,16,... with no gaps or duplicates.
- Full FIFO with redirect=1, redirect_pc=0x40, out_ready=1 -> old head counted as popped; next edge FIFO empty; out_pc=0x40 valid exactly one edge later.
- Sequential fetch to pc 1020 (MEM_SIZE=1024) -> entry 1020 pushed; fetch at 1024 faults with fault=1, fault_pc=1024; buffered entries drain; no further pushes.
- In FAULT, redirect_pc=0x22 -> remains FAULT, fault_pc=0x22. Then redirect_pc=0x20 -> fault=0, FETCH resumes, out_pc=0x20.
- Assert reset asynchronously mid-stream, between edges -> out_valid=0, fault=0, and imem_addr=RESET_PC before the next clk edge.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction-fetch block.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package fetch_pkg;

    typedef enum logic {
        FETCH = 1'b0,
        FAULT = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    localparam logic [63:0] INSTR_BYTES = 64'd4;

    // A fetch address is legal when word aligned and the whole word lies
    // inside the ROM. The +3 wraps at 64 bits, so addresses near the top of
    // the 64-bit space wrap to small values and must stay unsigned.
    function automatic logic addr_legal(input logic [63:0] addr,
                                        input logic [63:0] mem_size);
        return (addr[1:0] == 2'b00) && ((addr + 64'd3) < mem_size);
    endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// Bundle of fetch-side signals: ROM port, decode handshake, redirect, fault.
// Latency: n/a (wiring only).
// Backpressure: decode throttles through out_ready; the ROM port never stalls.
// master: the fetch sequencer. slave: ROM, decode and execute.
interface fetch_ctrl_if;
    logic [63:0] imem_addr;
    logic [31:0] imem_instr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [63:0] out_pc;
    logic        redirect;
    logic [63:0] redirect_pc;
    logic        fault;
    logic [63:0] fault_pc;

    modport master (
        output imem_addr,
        input  imem_instr,
        output out_valid,
        input  out_ready,
        output out_instr,
        output out_pc,
        input  redirect,
        input  redirect_pc,
        output fault,
        output fault_pc
    );

    modport slave (
        input  imem_addr,
        output imem_instr,
        input  out_valid,
        output out_ready,
        input  out_instr,
        input  out_pc,
        output redirect,
        output redirect_pc,
        input  fault,
        input  fault_pc
    );
endinterface

// File: rtl/fetch_fifo.sv
// Prefetch FIFO of {pc, instr} entries with synchronous flush.
// Latency: a push is visible at head one edge later when the FIFO was empty.
// Backpressure: caller must not push when full unless popping the same cycle.
// Ports: clk, reset, push, pop, flush, wdata (in); full, empty, head (out).
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t wdata,
    output logic         full,
    output logic         empty,
    output fetch_entry_t head
);

    localparam int AW = $clog2(DEPTH);

    fetch_entry_t    mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count;

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

    // Pointers are exactly log2(DEPTH) bits so they wrap without compare.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: nothing reads it while empty is asserted.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= wdata;
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, fills a prefetch FIFO, handles redirects and faults.
// Latency: a fetched word is offered to decode one edge after its PC was presented to the ROM.
// Backpressure: decode stalls via out_ready; a full FIFO holds the PC and ROM address steady.
// Ports: clk, reset; bus (master) carries ROM address/data, decode handshake, redirect, fault.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [63:0] RESET_PC = 64'd0,
    parameter int unsigned MEM_SIZE = 1024,
    parameter int          DEPTH    = 4
) (
    input  logic          clk,
    input  logic          reset,
    fetch_ctrl_if.master  bus
);

    localparam logic [63:0] MEM_BYTES = 64'(MEM_SIZE);

    fetch_state_e state;
    fetch_state_e state_nx;
    logic [63:0]  fetch_pc;
    logic [63:0]  fetch_pc_nx;
    logic [63:0]  fault_pc_r;
    logic [63:0]  fault_pc_nx;

    logic         push;
    logic         pop;
    logic         flush;
    logic         full;
    logic         empty;
    fetch_entry_t head;
    fetch_entry_t wdata;

    assign bus.imem_addr = fetch_pc;
    assign bus.out_valid = !empty;
    // Gate the head so stale storage never leaks out while nothing is valid.
    assign bus.out_instr = empty ? '0 : head.instr;
    assign bus.out_pc    = empty ? '0 : head.pc;
    assign bus.fault     = (state == FAULT);
    assign bus.fault_pc  = fault_pc_r;

    assign pop       = bus.out_valid && bus.out_ready;
    assign wdata.pc    = fetch_pc;
    assign wdata.instr = bus.imem_instr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= FETCH;
            fetch_pc   <= RESET_PC;
            fault_pc_r <= '0;
        end else begin
            state      <= state_nx;
            fetch_pc   <= fetch_pc_nx;
            fault_pc_r <= fault_pc_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        fetch_pc_nx = fetch_pc;
        fault_pc_nx = fault_pc_r;
        push        = 1'b0;
        flush       = 1'b0;

        if (bus.redirect) begin
            // Redirect wins in any state; the FIFO flush also drops the word
            // that would otherwise have been pushed this cycle.
            flush       = 1'b1;
            fetch_pc_nx = bus.redirect_pc;
            if (addr_legal(bus.redirect_pc, MEM_BYTES)) begin
                state_nx = FETCH;
            end else begin
                state_nx    = FAULT;
                fault_pc_nx = bus.redirect_pc;
            end
        end else begin
            case (state)
                FETCH: begin
                    if (!addr_legal(fetch_pc, MEM_BYTES)) begin
                        state_nx    = FAULT;
                        fault_pc_nx = fetch_pc;
                    end else if (!full || pop) begin
                        push        = 1'b1;
                        fetch_pc_nx = fetch_pc + INSTR_BYTES;
                    end
                end
                FAULT: begin
                    // Parked: only a legal redirect or reset leaves.
                end
                default: begin
                    state_nx = FETCH;
                end
            endcase
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .wdata (wdata),
        .full  (full),
        .empty (empty),
        .head  (head)
    );

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with a scoreboard of expected decode-side PCs.
module tb_fetch_ctrl;

    localparam logic [63:0] RESET_PC = 64'd0;
    localparam int unsigned MEM_SIZE = 1024;
    localparam int          DEPTH    = 4;

    logic clk;
    logic reset;

    fetch_ctrl_if bus ();

    fetch_ctrl #(
        .RESET_PC (RESET_PC),
        .MEM_SIZE (MEM_SIZE),
        .DEPTH    (DEPTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;
    logic [63:0] exp_q [$];

    function automatic logic [31:0] rom_word(input logic [63:0] a);
        return {a[15:0] ^ 16'hA5C3, a[15:0]};
    endfunction

    assign bus.imem_instr = rom_word(bus.imem_addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks = n_checks + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Every handshake that will complete at the next edge is checked here.
    always @(negedge clk) begin
        if (!reset && bus.out_valid && bus.out_ready) begin
            logic [63:0] e;
            check("sb_expected_avail", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("sb_pc", bus.out_pc, e);
                check("sb_instr", 64'(bus.out_instr), 64'(rom_word(e)));
            end
        end
    end

    initial begin
        reset           = 1'b1;
        bus.out_ready   = 1'b1;
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;

        // Phase 1: reset values, then streaming with out_ready held high.
        @(negedge clk);
        check("rst_valid", 64'(bus.out_valid), 64'd0);
        check("rst_instr", 64'(bus.out_instr), 64'd0);
        check("rst_pc", bus.out_pc, 64'd0);
        check("rst_fault", 64'(bus.fault), 64'd0);
        check("rst_fault_pc", bus.fault_pc, 64'd0);
        check("rst_imem_addr", bus.imem_addr, RESET_PC);
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < 4; i++) exp_q.push_back(64'(i * 4));
        @(negedge clk);
        check("p1_valid_before_first_edge", 64'(bus.out_valid), 64'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("p1_valid_consecutive", 64'(bus.out_valid), 64'd1);
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check("p1_sb_drained", 64'(exp_q.size()), 64'd0);

        // Phase 2: stall with decode blocked, then release.
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (10) @(negedge clk);
        check("p2_stall_imem_addr", bus.imem_addr, 64'd16);
        check("p2_stall_valid", 64'(bus.out_valid), 64'd1);
        check("p2_stall_head_pc", bus.out_pc, 64'd0);
        @(posedge clk); #1;
        for (int i = 0; i < 8; i++) exp_q.push_back(64'(i * 4));
        bus.out_ready = 1'b1;
        repeat (8) @(negedge clk);
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        @(negedge clk);
        check("p2_sb_drained", 64'(exp_q.size()), 64'd0);
        check("p2_imem_addr_after", bus.imem_addr, 64'd48);
        check("p2_head_after", bus.out_pc, 64'd32);

        // Phase 3: redirect while full; the head is still accepted.
        @(posedge clk); #1;
        exp_q.push_back(64'd32);
        bus.redirect    = 1'b1;
        bus.redirect_pc = 64'h40;
        bus.out_ready   = 1'b1;
        @(posedge clk); #1;
        bus.redirect  = 1'b0;
        bus.out_ready = 1'b0;
        @(negedge clk);
        check("p3_sb_drained", 64'(exp_q.size()), 64'd0);
        check("p3_flushed_valid", 64'(bus.out_valid), 64'd0);
        check("p3_imem_addr", bus.imem_addr, 64'h40);
        @(negedge clk);
        check("p3_target_valid", 64'(bus.out_valid), 64'd1);
        check("p3_target_pc", bus.out_pc, 64'h40);
        check("p3_target_instr", 64'(bus.out_instr), 64'(rom_word(64'h40)));

        // Phase 4: run off the end of the ROM.
        @(posedge clk); #1;
        exp_q.push_back(64'h40);
        bus.redirect    = 1'b1;
        bus.redirect_pc = 64'd1008;
        bus.out_ready   = 1'b1;
        @(posedge clk); #1;
        bus.redirect = 1'b0;
        for (int i = 0; i < 4; i++) exp_q.push_back(64'd1008 + 64'(i * 4));
        for (int i = 0; i < 20 && !bus.fault; i++) @(negedge clk);
        check("p4_fault", 64'(bus.fault), 64'd1);
        check("p4_fault_pc", bus.fault_pc, 64'd1024);
        repeat (6) @(negedge clk);
        check("p4_sb_drained", 64'(exp_q.size()), 64'd0);
        check("p4_no_push_valid", 64'(bus.out_valid), 64'd0);
        check("p4_imem_addr_held", bus.imem_addr, 64'd1024);
        check("p4_fault_held", 64'(bus.fault), 64'd1);

        // Phase 5: misaligned redirect stays faulted, aligned one recovers.
        @(posedge clk); #1;
        bus.redirect    = 1'b1;
        bus.redirect_pc = 64'h22;
        @(posedge clk); #1;
        bus.redirect = 1'b0;
        @(negedge clk);
        check("p5_misaligned_fault", 64'(bus.fault), 64'd1);
        check("p5_misaligned_fault_pc", bus.fault_pc, 64'h22);
        check("p5_misaligned_imem_addr", bus.imem_addr, 64'h22);
        check("p5_misaligned_valid", 64'(bus.out_valid), 64'd0);
        @(posedge clk); #1;
        bus.redirect    = 1'b1;
        bus.redirect_pc = 64'h20;
        @(posedge clk); #1;
        bus.redirect = 1'b0;
        exp_q.push_back(64'h20);
        @(negedge clk);
        check("p5_recover_fault", 64'(bus.fault), 64'd0);
        check("p5_recover_valid_early", 64'(bus.out_valid), 64'd0);
        @(negedge clk);
        check("p5_recover_pc", bus.out_pc, 64'h20);
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check("p5_sb_drained", 64'(exp_q.size()), 64'd0);

        // Phase 6: asynchronous reset between edges.
        repeat (3) @(negedge clk);
        check("p6_pre_valid", 64'(bus.out_valid), 64'd1);
        #2 reset = 1'b1;
        #1;
        check("p6_async_valid", 64'(bus.out_valid), 64'd0);
        check("p6_async_imem_addr", bus.imem_addr, RESET_PC);
        check("p6_async_out_pc", bus.out_pc, 64'd0);
        @(posedge clk); #1;
        reset           = 1'b0;
        bus.redirect    = 1'b1;
        bus.redirect_pc = 64'h1000;
        @(posedge clk); #1;
        bus.redirect = 1'b0;
        @(negedge clk);
        check("p6_oob_fault", 64'(bus.fault), 64'd1);
        check("p6_oob_fault_pc", bus.fault_pc, 64'h1000);
        #2 reset = 1'b1;
        #1;
        check("p6_async_fault", 64'(bus.fault), 64'd0);
        check("p6_async_fault_pc", bus.fault_pc, 64'd0);
        check("p6_async_imem_addr2", bus.imem_addr, RESET_PC);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
